// File: rtl/sram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_port_arbiter_pkg
//  Description : Shared types and limits for the SRAM port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_port_arbiter_pkg;

  // Largest requester count the arbiter is built for
  localparam int MAX_REQ = 8;

  // Arbiter mode: plain round-robin, or grant held by a single owner
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sram_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Rotates the request
//                vector so that index ptr lands at position 0,
//                priority-encodes the lowest set bit, then rotates the
//                one-hot result back to the original requester positions.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [N-1:0] w_rot;
  logic [N-1:0] w_pick;
  logic         w_found;

  // Requester position that sits at rotated slot off; ptr is always < N
  function automatic int wrap_idx(input int base, input int off);
    return (base + off) % N;
  endfunction

  // Rotate so the requester at ptr has the highest priority (slot 0)
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < N; j++) begin
      w_rot[j] = req[wrap_idx(int'(ptr), j)];
    end
  end

  // Keep only the lowest set rotated bit
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (w_rot[j] && !w_found) begin
        w_pick[j] = 1'b1;
        w_found   = 1'b1;
      end
    end
  end

  // Rotate the one-hot pick back to requester numbering
  always_comb begin
    gnt = '0;
    for (int j = 0; j < N; j++) begin
      gnt[wrap_idx(int'(ptr), j)] = w_pick[j];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_port_arbiter
//  Description : Shares one single-port synchronous SRAM (1-cycle registered
//                read) between N_REQ requesters. Per-cycle round-robin
//                grant, req/gnt handshake, read data returned with a one-hot
//                rvalid naming the requester that owns it.
//                Optional macro SRAM_ARB_LOCK_EN adds grant locking: a
//                requester granted with lock=1 keeps the port for up to
//                MAX_LOCK consecutive grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LOCK   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
  input  logic [N_REQ-1:0]            lock,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        sram_cs,
  output logic                        sram_we,
  output logic [ADDR_WIDTH-1:0]       sram_addr,
  output logic [DATA_WIDTH-1:0]       sram_din,
  input  logic [DATA_WIDTH-1:0]       sram_dout
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [N_REQ-1:0]   r_rvalid;
  logic [N_REQ-1:0]   w_req_arb;
  logic [N_REQ-1:0]   w_rr_gnt;
  logic [N_REQ-1:0]   w_gnt_raw;
  logic [PTR_W-1:0]   w_win_idx;
  logic [PTR_W-1:0]   w_win_inc;

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req (w_req_arb),
    .ptr (r_ptr),
    .gnt (w_rr_gnt)
  );

  // Grants are suppressed while reset is asserted, even with req raised
  assign gnt     = rst_n ? w_gnt_raw : '0;
  assign sram_cs = |gnt;
  assign rvalid  = r_rvalid;
  assign rdata   = sram_dout;

  // Encode the granted requester and the pointer value just past it
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) w_win_idx = PTR_W'(i);
    end
    w_win_inc = (w_win_idx == PTR_W'(N_REQ - 1)) ? '0 : w_win_idx + PTR_W'(1);
  end

  // Route the winner's command to the SRAM; all-zero when nobody is granted
  always_comb begin
    sram_we   = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sram_we   = we[i];
        sram_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sram_din  = wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State register: arbiter mode and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Read-return pipeline: the SRAM output is valid one cycle after a read grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= '0;
    end else begin
      r_rvalid <= gnt & ~we;
    end
  end

`ifdef SRAM_ARB_LOCK_EN

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  logic [PTR_W-1:0] r_owner;
  logic [CNT_W-1:0] r_lock_cnt;
  logic [N_REQ-1:0] w_owner_oh;
  logic [PTR_W-1:0] w_owner_inc;
  logic             w_locked;
  logic             w_at_max;
  logic             w_exit;
  logic             w_normal;

  assign w_owner_oh  = N_REQ'(1) << r_owner;
  assign w_owner_inc = (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);
  assign w_locked    = (r_state == ARB_LOCKED);
  assign w_at_max    = (r_lock_cnt == CNT_W'(MAX_LOCK));
  // The exit cycle behaves like an idle cycle, so it arbitrates normally
  assign w_exit      = w_locked && (!lock[r_owner] || w_at_max);
  assign w_normal    = !w_locked || w_exit;
  // An owner that used up its lock budget sits out the exit cycle
  assign w_req_arb   = (w_locked && w_at_max) ? (req & ~w_owner_oh) : req;

  // Output logic: round-robin pick, or the owner alone while locked
  always_comb begin
    w_gnt_raw = w_rr_gnt;
    if (!w_normal) w_gnt_raw = req & w_owner_oh;
  end

  // Next-state logic: a locking grant enters ARB_LOCKED, exit returns to idle
  always_comb begin
    w_state_nxt = r_state;
    if (w_normal) w_state_nxt = (|(gnt & lock)) ? ARB_LOCKED : ARB_IDLE;
  end

  // Pointer frozen while locked; on an exit without a grant it moves past the owner
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_normal && |gnt) w_ptr_nxt = w_win_inc;
    else if (w_exit)      w_ptr_nxt = w_owner_inc;
  end

  // Lock owner and count of consecutive grants held by it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= '0;
      r_lock_cnt <= '0;
    end else if (w_normal) begin
      if (|(gnt & lock)) begin
        r_owner    <= w_win_idx;
        r_lock_cnt <= CNT_W'(1);
      end else begin
        r_lock_cnt <= '0;
      end
    end else if (|gnt) begin
      r_lock_cnt <= r_lock_cnt + CNT_W'(1);
    end
  end

`else

  // Lock input and MAX_LOCK have no effect in the plain round-robin build
  logic w_unused_lock;
  assign w_unused_lock = ^{lock, 32'(MAX_LOCK)};

  assign w_req_arb = req;

  // Output logic: plain round-robin pick
  always_comb begin
    w_gnt_raw = w_rr_gnt;
  end

  // Next-state logic: only the idle mode exists
  always_comb begin
    w_state_nxt = ARB_IDLE;
  end

  // Pointer moves past each winner and holds on idle cycles
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (|gnt) w_ptr_nxt = w_win_inc;
  end

`endif

endmodule
`default_nettype wire
